// File: rtl/bcd_timer_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_timer_core: DIGITS-wide BCD up/down timer, start/pause/clear FSM.    |
// | Macro BCD_TIMER_BLANK_LEADING_EN blanks leading-zero digits on seg.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_timer_core #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIGITS-1:0]   btn_inc,
    input  logic                btn_start_pause,
    input  logic                btn_clear,
    input  logic                mode_down,
    output logic [4*DIGITS-1:0] bcd_num,
    output logic [7*DIGITS-1:0] seg,
    output logic [1:0]          fsm_state,
    output logic                done,
    output logic                tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]       C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] C_ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                mode_q, mode_d;
    logic                tick_q, tick_d;
    logic [DIGITS-1:0]   inc_prev_q, inc_prev_d;
    logic                sp_prev_q, sp_prev_d;
    logic                clr_prev_q, clr_prev_d;

    logic [DIGITS-1:0]   w_ev_inc;
    logic                w_ev_sp, w_ev_clr, w_sp_act;
    logic [4*DIGITS-1:0] w_bcd_up, w_bcd_dn;
    logic [DIGITS-1:0]   w_blank;

    assign w_ev_inc = btn_inc & ~inc_prev_q;
    assign w_ev_sp  = btn_start_pause & ~sp_prev_q;
    assign w_ev_clr = btn_clear & ~clr_prev_q;
    // A start from IDLE with nothing to count down from is not a transition.
    assign w_sp_act = (state_q != S_DONE) &&
                      !(state_q == S_IDLE && mode_down && bcd_q == '0);

    always_comb begin : p_bcd_step
        logic carry;
        logic borrow;
        w_bcd_up = bcd_q;
        w_bcd_dn = bcd_q;
        carry    = 1'b1;
        borrow   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    w_bcd_up[4*i +: 4] = 4'd0;
                end else begin
                    w_bcd_up[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd_q[4*i +: 4] == 4'd0) begin
                    w_bcd_dn[4*i +: 4] = 4'd9;
                end else begin
                    w_bcd_dn[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        presc_d    = presc_q;
        mode_d     = mode_q;
        tick_d     = 1'b0;
        inc_prev_d = btn_inc;
        sp_prev_d  = btn_start_pause;
        clr_prev_d = btn_clear;

        if (w_ev_clr) begin
            bcd_d   = '0;
            presc_d = '0;
            state_d = S_IDLE;
        end else if (w_ev_sp && w_sp_act) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                    mode_d  = mode_down;
                    presc_d = '0;
                end
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end else if (state_q == S_IDLE || state_q == S_PAUSE) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_ev_inc[i]) begin
                    bcd_d[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0
                                                               : bcd_q[4*i +: 4] + 4'd1;
                end
            end
        end else if (state_q == S_RUN) begin
            if (presc_q == C_PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (mode_q) begin
                    bcd_d = w_bcd_dn;
                    if (w_bcd_dn == '0) state_d = S_DONE;
                end else begin
                    bcd_d = w_bcd_up;
                    if (w_bcd_up == C_ALL_NINES) state_d = S_DONE;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // History regs reset high so a button held through reset is not an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bcd_q      <= '0;
            presc_q    <= '0;
            mode_q     <= 1'b0;
            tick_q     <= 1'b0;
            inc_prev_q <= '1;
            sp_prev_q  <= 1'b1;
            clr_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            presc_q    <= presc_d;
            mode_q     <= mode_d;
            tick_q     <= tick_d;
            inc_prev_q <= inc_prev_d;
            sp_prev_q  <= sp_prev_d;
            clr_prev_q <= clr_prev_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

`ifdef BCD_TIMER_BLANK_LEADING_EN
    // Scan from the top digit; a digit blanks while everything above and at it is zero.
    always_comb begin : p_blank
        logic any_nz;
        any_nz  = 1'b0;
        w_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz     = any_nz | (bcd_q[4*i +: 4] != 4'd0);
            w_blank[i] = (i != 0) && !any_nz;
        end
    end
`else
    assign w_blank = '0;
`endif

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_seg
            assign seg[7*g +: 7] = w_blank[g] ? 7'b0000000 : seg7(bcd_q[4*g +: 4]);
        end
    endgenerate

    assign bcd_num   = bcd_q;
    assign fsm_state = state_q;
    assign done      = (state_q == S_DONE);
    assign tick      = tick_q;

endmodule
`default_nettype wire
